// File: rtl/dff_mem_burst.sv
// Parametrised flip-flop RAM with a valid/ready command port, auto-increment burst pointer
// and a sequenced clear engine that fills every word with CLEAR_VAL.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | accepting WRITE / READ / SEEK / CLEAR commands
// S_CLEAR | sweeping clr_idx 0..DEPTH-1; the first edge after reset only arms
module dff_mem_burst #(
    parameter int unsigned       DATA_W         = 8,
    parameter int unsigned       DEPTH          = 16,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    localparam int unsigned      ADDR_W         = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_use_ptr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy,
    output logic              clr_done,
    output logic              addr_err
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_SEEK  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_idx;

    logic              accept;
    logic [ADDR_W-1:0] eff_addr;
    logic              eff_ok;
    logic              seek_ok;
    logic [ADDR_W-1:0] next_ptr;
    logic              do_write;
    logic              clr_we;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready & rst_n;
    assign eff_addr  = cmd_use_ptr ? ptr : cmd_addr;
    assign eff_ok    = ({1'b0, eff_addr} < DEPTH_X);
    assign seek_ok   = ({1'b0, cmd_addr} < DEPTH_X);
    assign next_ptr  = (eff_addr == LAST_IDX) ? '0 : eff_addr + ADDR_W'(1);
    assign do_write  = accept & (cmd_op == OP_WRITE) & eff_ok;
    // busy doubles as the sweep arm flag, so no word is written while reset is held
    assign clr_we    = (state == S_CLEAR) & busy;

    // The array is deliberately not reset; only the clear sweep or writes define it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= CLEAR_VAL;
        end else if (do_write) begin
            mem[eff_addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            rdata    <= '0;
            rvalid   <= 1'b0;
            ptr      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
            addr_err <= 1'b0;
            clr_idx  <= '0;
        end else begin
            rvalid   <= 1'b0;
            clr_done <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                if (eff_ok) ptr <= next_ptr;
                                else        addr_err <= 1'b1;
                            end
                            OP_READ: begin
                                rvalid <= 1'b1;
                                if (eff_ok) begin
                                    rdata <= mem[eff_addr];
                                    ptr   <= next_ptr;
                                end else begin
                                    rdata    <= '0;
                                    addr_err <= 1'b1;
                                end
                            end
                            OP_SEEK: begin
                                if (seek_ok) ptr <= cmd_addr;
                                else         addr_err <= 1'b1;
                            end
                            OP_CLEAR: begin
                                state   <= S_CLEAR;
                                busy    <= 1'b1;
                                clr_idx <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLEAR: begin
                    if (!busy) begin
                        busy <= 1'b1;
                    end else if (clr_idx == LAST_IDX) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                        ptr      <= '0;
                        clr_idx  <= '0;
                    end else begin
                        clr_idx <= clr_idx + ADDR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_mem_burst.sv
// Bench for dff_mem_burst: a 16-word power-of-two instance and a 12-word instance,
// each driven through the command port and compared against an array-based model.
module tb_dff_mem_burst;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_W = 2'b00;
    localparam logic [1:0] OP_R = 2'b01;
    localparam logic [1:0] OP_S = 2'b10;
    localparam logic [1:0] OP_C = 2'b11;

    logic       a_rst_n, a_valid, a_ready, a_use_ptr, a_rvalid, a_busy, a_clr_done, a_addr_err;
    logic [1:0] a_op;
    logic [3:0] a_addr, a_ptr;
    logic [7:0] a_wdata, a_rdata;

    logic       b_rst_n, b_valid, b_ready, b_use_ptr, b_rvalid, b_busy, b_clr_done, b_addr_err;
    logic [1:0] b_op;
    logic [3:0] b_addr, b_ptr;
    logic [7:0] b_wdata, b_rdata;

    dff_mem_burst #(.DATA_W(8), .DEPTH(16), .CLEAR_VAL(8'hA5), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(a_op),
        .cmd_use_ptr(a_use_ptr), .cmd_addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
        .rvalid(a_rvalid), .ptr(a_ptr), .busy(a_busy), .clr_done(a_clr_done), .addr_err(a_addr_err)
    );

    dff_mem_burst #(.DATA_W(8), .DEPTH(12), .CLEAR_VAL(8'h5A), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
        .cmd_use_ptr(b_use_ptr), .cmd_addr(b_addr), .wdata(b_wdata), .rdata(b_rdata),
        .rvalid(b_rvalid), .ptr(b_ptr), .busy(b_busy), .clr_done(b_clr_done), .addr_err(b_addr_err)
    );

    // reference model of whichever instance is under test
    logic [7:0] m_mem [16];
    int         m_ptr;
    int         m_depth;
    logic [7:0] m_rdata;
    logic [7:0] m_clear;
    logic       m_err;

    function automatic void model_step(input logic [1:0] op, input logic up, input int addr,
                                       input logic [7:0] wd);
        int a;
        a = up ? m_ptr : addr;
        m_err = 1'b0;
        case (op)
            OP_W: if (a < m_depth) begin m_mem[a] = wd; m_ptr = (a + 1) % m_depth; end
                  else m_err = 1'b1;
            OP_R: if (a < m_depth) begin m_rdata = m_mem[a]; m_ptr = (a + 1) % m_depth; end
                  else begin m_rdata = 8'h00; m_err = 1'b1; end
            OP_S: if (addr < m_depth) m_ptr = addr; else m_err = 1'b1;
            default: begin
                for (int i = 0; i < 16; i++) m_mem[i] = m_clear;
                m_ptr = 0;
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command, waits (bounded) for acceptance, returns one sample after the accept edge.
    task automatic cmd_a(input logic [1:0] op, input logic up, input logic [3:0] addr,
                         input logic [7:0] wd);
        int waited = 0;
        a_valid = 1'b1; a_op = op; a_use_ptr = up; a_addr = addr; a_wdata = wd;
        while (!a_ready && waited < 100) begin step(); waited++; end
        total++;
        if (!a_ready) begin
            bad++;
            $display("FAIL cmd_a_accept_timeout ready=%0b required=1", a_ready);
            a_valid = 1'b0;
            return;
        end
        step();
        a_valid = 1'b0;
        model_step(op, up, int'(addr), wd);
    endtask

    task automatic cmd_b(input logic [1:0] op, input logic up, input logic [3:0] addr,
                         input logic [7:0] wd);
        int waited = 0;
        b_valid = 1'b1; b_op = op; b_use_ptr = up; b_addr = addr; b_wdata = wd;
        while (!b_ready && waited < 100) begin step(); waited++; end
        total++;
        if (!b_ready) begin
            bad++;
            $display("FAIL cmd_b_accept_timeout ready=%0b required=1", b_ready);
            b_valid = 1'b0;
            return;
        end
        step();
        b_valid = 1'b0;
        model_step(op, up, int'(addr), wd);
    endtask

    task automatic test_reset();
        int low = 0, bz = 0, dn = 0;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        step(); step();
        total++;
        if ({a_rdata, a_rvalid, a_ptr, a_busy, a_clr_done, a_addr_err} !== 17'd0) begin
            bad++; $display("FAIL reset_a_outputs got=%h required=0",
                            {a_rdata, a_rvalid, a_ptr, a_busy, a_clr_done, a_addr_err});
        end
        total++;
        if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b required=0", a_ready); end
        total++;
        if ({b_rdata, b_rvalid, b_ptr, b_busy, b_clr_done, b_addr_err} !== 17'd0) begin
            bad++; $display("FAIL reset_b_outputs got=%h required=0",
                            {b_rdata, b_rvalid, b_ptr, b_busy, b_clr_done, b_addr_err});
        end
        total++;
        if (b_ready !== 1'b1) begin bad++; $display("FAIL reset_b_ready got=%b required=1", b_ready); end

        a_rst_n = 1'b1; b_rst_n = 1'b1;
        for (int c = 0; c < 24; c++) begin
            step();
            if (!a_ready) low++;
            if (a_busy) bz++;
            if (a_clr_done) dn++;
        end
        total++;
        if (low != 16) begin bad++; $display("FAIL post_reset_ready_low got=%0d required=16", low); end
        total++;
        if (bz != 16) begin bad++; $display("FAIL post_reset_busy got=%0d required=16", bz); end
        total++;
        if (dn != 1) begin bad++; $display("FAIL post_reset_clr_done got=%0d required=1", dn); end

        m_depth = 16; m_clear = 8'hA5; m_ptr = 0; m_rdata = 8'h00;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            cmd_a(OP_R, 1'b0, 4'(i), 8'h00);
            total++;
            if (a_rvalid !== 1'b1 || a_rdata !== 8'hA5) begin
                bad++; $display("FAIL post_reset_read[%0d] rvalid=%b rdata=%h required=1/a5", i, a_rvalid, a_rdata);
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] vals [4];
        logic [3:0] exp_ptr [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_ptr = '{4'd15, 4'd0, 4'd1, 4'd2};
        cmd_a(OP_S, 1'b1, 4'd14, 8'hFF);
        total++;
        if (a_ptr !== 4'd14) begin bad++; $display("FAIL burst_seek ptr=%0d required=14", a_ptr); end
        for (int i = 0; i < 4; i++) begin
            cmd_a(OP_W, 1'b1, 4'd3, vals[i]);
            total++;
            if (a_ptr !== exp_ptr[i]) begin
                bad++; $display("FAIL burst_write_ptr[%0d] got=%0d required=%0d", i, a_ptr, exp_ptr[i]);
            end
        end
        cmd_a(OP_S, 1'b0, 4'd14, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cmd_a(OP_R, 1'b1, 4'd7, 8'h00);
            total++;
            if (a_rvalid !== 1'b1 || a_rdata !== vals[i] || a_ptr !== exp_ptr[i]) begin
                bad++; $display("FAIL burst_read[%0d] rvalid=%b rdata=%h ptr=%0d required=1/%h/%0d",
                                i, a_rvalid, a_rdata, a_ptr, vals[i], exp_ptr[i]);
            end
        end
    endtask

    task automatic test_explicit();
        cmd_a(OP_W, 1'b0, 4'd5, 8'h3C);
        total++;
        if (a_ptr !== 4'd6 || a_rvalid !== 1'b0) begin
            bad++; $display("FAIL explicit_write ptr=%0d rvalid=%b required=6/0", a_ptr, a_rvalid);
        end
        cmd_a(OP_R, 1'b0, 4'd5, 8'h00);
        total++;
        if (a_rvalid !== 1'b1 || a_rdata !== 8'h3C || a_ptr !== 4'd6) begin
            bad++; $display("FAIL explicit_read rvalid=%b rdata=%h ptr=%0d required=1/3c/6", a_rvalid, a_rdata, a_ptr);
        end
        step();
        total++;
        if (a_rvalid !== 1'b0 || a_rdata !== 8'h3C) begin
            bad++; $display("FAIL explicit_rvalid_pulse rvalid=%b rdata=%h required=0/3c", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic       up;
        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom_range(0, 2));
            up = 1'($urandom_range(0, 1));
            cmd_a(op, up, 4'($urandom_range(0, 15)), 8'($urandom));
            total++;
            if (a_ptr !== 4'(m_ptr) || a_rvalid !== (op == OP_R) || a_rdata !== m_rdata || a_addr_err !== 1'b0) begin
                bad++; $display("FAIL random[%0d] op=%0d ptr=%0d rvalid=%b rdata=%h err=%b required=%0d/%b/%h/0",
                                n, op, a_ptr, a_rvalid, a_rdata, a_addr_err, m_ptr, (op == OP_R), m_rdata);
            end
            if ($urandom_range(0, 3) == 0) begin
                step();
                total++;
                if (a_rvalid !== 1'b0 || a_rdata !== m_rdata) begin
                    bad++; $display("FAIL random_idle[%0d] rvalid=%b rdata=%h required=0/%h", n, a_rvalid, a_rdata, m_rdata);
                end
            end
        end
    endtask

    task automatic test_clear_handshake();
        int bz = 0, early = 0, cyc = 0;
        cmd_a(OP_C, 1'b0, 4'd0, 8'h00);
        a_valid = 1'b1; a_op = OP_W; a_use_ptr = 1'b0; a_addr = 4'd3; a_wdata = 8'h77;
        while (!a_ready && cyc < 50) begin
            if (a_busy) bz++;
            if (a_clr_done) early++;
            step();
            cyc++;
        end
        total++;
        if (a_ready !== 1'b1 || a_clr_done !== 1'b1 || early != 0) begin
            bad++; $display("FAIL clear_ready_with_done ready=%b clr_done=%b early=%0d required=1/1/0", a_ready, a_clr_done, early);
        end
        total++;
        if (bz != 16) begin bad++; $display("FAIL clear_busy_cycles got=%0d required=16", bz); end
        step();
        a_valid = 1'b0;
        model_step(OP_W, 1'b0, 3, 8'h77);
        total++;
        if (a_ptr !== 4'd4) begin bad++; $display("FAIL clear_held_write_ptr got=%0d required=4", a_ptr); end
        for (int i = 0; i < 16; i++) begin
            cmd_a(OP_R, 1'b0, 4'(i), 8'h00);
            total++;
            if (a_rdata !== m_rdata) begin
                bad++; $display("FAIL clear_readback[%0d] got=%h required=%h", i, a_rdata, m_rdata);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int low = 0, bz = 0, dn = 0;
        for (int i = 10; i < 16; i++) cmd_a(OP_W, 1'b0, 4'(i), 8'(8'h10 + i));
        cmd_a(OP_R, 1'b0, 4'd10, 8'h00);
        cmd_a(OP_C, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 6; i++) step();
        total++;
        if (a_busy !== 1'b1 || a_ptr !== 4'd11 || a_rdata !== 8'h1A) begin
            bad++; $display("FAIL mid_sweep_pre busy=%b ptr=%0d rdata=%h required=1/11/1a", a_busy, a_ptr, a_rdata);
        end
        a_rst_n = 1'b0;
        #1;
        total++;
        if ({a_rdata, a_rvalid, a_ptr, a_busy, a_clr_done, a_addr_err, a_ready} !== 18'd0) begin
            bad++; $display("FAIL mid_sweep_reset got=%h required=0",
                            {a_rdata, a_rvalid, a_ptr, a_busy, a_clr_done, a_addr_err, a_ready});
        end
        step(); step();
        a_rst_n = 1'b1;
        for (int c = 0; c < 24; c++) begin
            step();
            if (!a_ready) low++;
            if (a_busy) bz++;
            if (a_clr_done) dn++;
        end
        total++;
        if (low != 16 || bz != 16 || dn != 1) begin
            bad++; $display("FAIL mid_sweep_rerun low=%0d busy=%0d done=%0d required=16/16/1", low, bz, dn);
        end
        m_ptr = 0; m_rdata = 8'h00;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            cmd_a(OP_R, 1'b0, 4'(i), 8'h00);
            total++;
            if (a_rdata !== 8'hA5) begin
                bad++; $display("FAIL mid_sweep_readback[%0d] got=%h required=a5", i, a_rdata);
            end
        end
    endtask

    task automatic test_non_pow2();
        int bz = 0, cyc = 0;
        m_depth = 12; m_clear = 8'h5A; m_ptr = 0; m_rdata = 8'h00;
        cmd_b(OP_C, 1'b0, 4'd0, 8'h00);
        while (!b_ready && cyc < 50) begin
            if (b_busy) bz++;
            step();
            cyc++;
        end
        total++;
        if (bz != 12 || b_clr_done !== 1'b1) begin
            bad++; $display("FAIL np2_clear busy=%0d clr_done=%b required=12/1", bz, b_clr_done);
        end
        cmd_b(OP_R, 1'b0, 4'd2, 8'h00);
        total++;
        if (b_rdata !== m_rdata || b_ptr !== 4'(m_ptr)) begin
            bad++; $display("FAIL np2_read2 rdata=%h ptr=%0d required=%h/%0d", b_rdata, b_ptr, m_rdata, m_ptr);
        end
        cmd_b(OP_W, 1'b0, 4'd13, 8'h99);
        total++;
        if (b_addr_err !== m_err || b_ptr !== 4'(m_ptr)) begin
            bad++; $display("FAIL np2_write_oor err=%b ptr=%0d required=%b/%0d", b_addr_err, b_ptr, m_err, m_ptr);
        end
        step();
        total++;
        if (b_addr_err !== 1'b0) begin bad++; $display("FAIL np2_err_pulse got=%b required=0", b_addr_err); end
        cmd_b(OP_R, 1'b0, 4'd13, 8'h00);
        total++;
        if (b_rvalid !== 1'b1 || b_rdata !== m_rdata || b_addr_err !== m_err || b_ptr !== 4'(m_ptr)) begin
            bad++; $display("FAIL np2_read_oor rvalid=%b rdata=%h err=%b ptr=%0d required=1/%h/%b/%0d",
                            b_rvalid, b_rdata, b_addr_err, b_ptr, m_rdata, m_err, m_ptr);
        end
        cmd_b(OP_S, 1'b0, 4'd13, 8'h00);
        total++;
        if (b_addr_err !== m_err || b_ptr !== 4'(m_ptr)) begin
            bad++; $display("FAIL np2_seek_oor err=%b ptr=%0d required=%b/%0d", b_addr_err, b_ptr, m_err, m_ptr);
        end
        cmd_b(OP_S, 1'b0, 4'd11, 8'h00);
        cmd_b(OP_W, 1'b1, 4'd0, 8'h42);
        total++;
        if (b_ptr !== 4'd0 || b_addr_err !== 1'b0) begin
            bad++; $display("FAIL np2_wrap ptr=%0d err=%b required=0/0", b_ptr, b_addr_err);
        end
        for (int i = 0; i < 12; i++) begin
            cmd_b(OP_R, 1'b0, 4'(i), 8'h00);
            total++;
            if (b_rdata !== m_rdata) begin
                bad++; $display("FAIL np2_readback[%0d] got=%h required=%h", i, b_rdata, m_rdata);
            end
        end
    endtask

    initial begin
        a_rst_n = 1'b0; a_valid = 1'b0; a_op = OP_W; a_use_ptr = 1'b0; a_addr = '0; a_wdata = '0;
        b_rst_n = 1'b0; b_valid = 1'b0; b_op = OP_W; b_use_ptr = 1'b0; b_addr = '0; b_wdata = '0;
        m_depth = 16; m_ptr = 0; m_rdata = 8'h00; m_clear = 8'hA5; m_err = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        test_reset();
        test_burst();
        test_explicit();
        test_random();
        test_clear_handshake();
        test_reset_mid_sweep();
        test_non_pow2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
